// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// instruction geometry and the IF/ID pipeline record.
package instruction_fetch_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [ILEN-1:0] HALT_WORD = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear drops only the valid bit (bubble), enable loads
// a new record, otherwise the record holds.
module if_id_reg
  import instruction_fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_en,
  input  logic   i_clr,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q.valid <= 1'b0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IDLE/RUN/HALT control, redirect handling
// and the IF/ID register feeding decode.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned size     = 64,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] adr,
  input  logic [31:0] Instruction,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [63:0] if_id_pc,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam logic [XLEN-1:0] LAST_PC = XLEN'(size) - XLEN'(INSTR_BYTES);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_halted;
  logic            r_misalign;
  logic [31:0]     r_count;

  logic   w_redirect;
  logic   w_advance;
  logic   w_in_range;
  logic   w_fetch;
  logic   w_clr;
  if_id_t w_d;
  if_id_t w_q;

  // Redirect outranks stall; range is checked in full 64 bits before the word is trusted.
  assign w_redirect = (r_state == RUN) && redirect_valid;
  assign w_advance  = (r_state == RUN) && !redirect_valid && !stall;
  assign w_in_range = (r_pc <= LAST_PC);
  assign w_fetch    = w_advance && w_in_range && (Instruction != HALT_WORD);
  assign w_clr      = w_redirect || (w_advance && !w_fetch);

  assign w_d.valid = 1'b1;
  assign w_d.instr = Instruction;
  assign w_d.pc    = r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_halted   <= 1'b0;
      r_misalign <= 1'b0;
      r_count    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) r_state <= RUN;
        end
        RUN: begin
          if (redirect_valid) begin
            r_pc <= {redirect_pc[63:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) r_misalign <= 1'b1;
          end else if (!stall) begin
            if (w_fetch) begin
              r_pc    <= r_pc + XLEN'(INSTR_BYTES);
              r_count <= r_count + 32'd1;
            end else begin
              r_state  <= HALT;
              r_halted <= 1'b1;
            end
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_fetch),
    .i_clr (w_clr),
    .i_d   (w_d),
    .o_q   (w_q)
  );

  assign adr          = r_pc;
  assign if_id_valid  = w_q.valid;
  assign if_id_instr  = w_q.instr;
  assign if_id_pc     = w_q.pc;
  assign halted       = r_halted;
  assign misalign_err = r_misalign;
  assign fetch_count  = r_count;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter size, default 64, giving the instruction memory size in bytes.
REQ-002 The block SHALL have parameter RESET_PC, default 64'h0, giving the PC loaded at reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  leaves IDLE and begins fetching.
REQ-006 stall  input  1  hazard hold from decode; freezes PC and the IF/ID register.
REQ-007 redirect_valid  input  1  taken branch or jump from a later stage.
REQ-008 redirect_pc  input  64  branch or jump target byte address.
REQ-009 adr  output  64  byte address to the instruction memory; equals pc_q combinationally.
REQ-010 Instruction  input  32  little-endian word returned combinationally by the memory for adr.
REQ-011 if_id_valid  output  1  the IF/ID register holds a real instruction.
REQ-012 if_id_instr  output  32  IF/ID instruction.
REQ-013 if_id_pc  output  64  PC of if_id_instr.
REQ-014 halted  output  1  FSM is in HALT.
REQ-015 misalign_err  output  1  sticky; a redirect_pc had bits [1:0] nonzero.
REQ-016 fetch_count  output  32  number of instructions delivered to IF/ID; wraps modulo 2^32.

Function
REQ-017 FSM states SHALL be IDLE, RUN and HALT.
- IDLE->RUN on start.
- RUN->HALT per REQ-022/REQ-023.
- HALT SHALL be exited only by reset.
REQ-018 In IDLE, pc_q SHALL hold and if_id_valid SHALL be 0; redirect and stall are ignored.
REQ-019 RUN, no redirect, stall=0, fetch in range and nonzero: next cycle SHALL give if_id_instr=Instruction, if_id_pc=pc_q, if_id_valid=1, pc_q+=4, fetch_count+=1. Throughput is one instruction per cycle; IF/ID latency is 1 cycle.
REQ-020 RUN, stall=1, no redirect: pc_q, the IF/ID register and fetch_count SHALL hold.
REQ-021 Redirect in RUN SHALL take priority over stall and over the halt checks:
- pc_q <= {redirect_pc[63:2],2'b00};
- if_id_valid <= 0 (one bubble);
- fetch_count holds;
- misalign_err is set if redirect_pc[1:0] != 0.
REQ-022 Out of range: in RUN, no redirect, stall=0 and pc_q > size-4 SHALL enter HALT with if_id_valid=0 and the memory word not used.
REQ-023 Halt word: in RUN, no redirect, stall=0, pc_q in range and Instruction == 32'h0 SHALL enter HALT with if_id_valid=0 and fetch_count unchanged.
REQ-024 In HALT, if_id_valid SHALL be 0; pc_q, if_id_pc, if_id_instr and fetch_count SHALL hold; halted=1.
REQ-025 PC arithmetic SHALL be 64-bit unsigned; pc_q+4 wraps silently. The range compare SHALL be made in 64 bits, not truncated to log2(size).

Reset
REQ-026 Asserting rst_n low SHALL, asynchronously and at any time including mid-fetch or while stalled, set:
- state=IDLE, pc_q=RESET_PC;
- if_id_valid=0, if_id_instr=0, if_id_pc=0;
- halted=0, misalign_err=0, fetch_count=0.
REQ-027 After rst_n deasserts, the first fetch SHALL occur no earlier than the clk edge following the one that samples start=1.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE/RUN/HALT), the constants INSTR_BYTES=4 and HALT_WORD=32'h0, and the IF/ID record struct (valid, instr, pc).
REQ-029 The IF/ID register SHALL be a sub-module named if_id_reg with enable (hold) and clear (bubble) inputs; PC and FSM logic SHALL stay in instruction_fetch.

Verification
REQ-030 Reset then start; memory holds 0x004101B3 @0, 0x0642A483 @4, 0x0074A023 @8, 0 @12 -> IF/ID shows (pc 0, 0x004101B3), (4, 0x0642A483), (8, 0x0074A023) on consecutive cycles, then halted=1 and fetch_count=3.
REQ-031 Stall held 2 cycles while if_id_pc=4 -> if_id_pc stays 4, adr stays 8, fetch_count is unchanged; resumes at pc 8 on release.
REQ-032 Redirect to 0x10 together with stall=1 while pc_q=8 -> next cycle adr=0x10 and if_id_valid=0; fetch at 0x10 follows once stall drops.
REQ-033 Redirect to 0x0A -> adr=0x08 and misalign_err=1 and remains 1 through later redirects.
REQ-034 size=64, redirect to 0x40 -> HALT next cycle with if_id_valid=0 and no memory word captured.
REQ-035 rst_n pulsed low mid-RUN, asynchronous to clk -> all outputs take their reset values immediately; pc_q=RESET_PC and state=IDLE.
